// File: rtl/uart_pkg.sv
// Shared definitions for the uart_cfg transmitter/receiver pair.
//   - parity mode constants
//   - frame state encoding used by both TX and RX state machines
//   - elaboration-time divisor functions and a parity helper
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    function automatic int tx_div(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

    function automatic int rx_div(input int clock_rate, input int baud_rate, input int oversample);
        return clock_rate / (baud_rate * oversample);
    endfunction

    // Payload is zero-extended to 9 bits; the extra zeros leave the XOR unchanged.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable baud divider. Counts 0..DIV-1 while enabled and raises tick_o
// for one cycle on the terminal count. restart_i forces the count back to 0
// so every frame starts with a full bit period.
//   clk       system clock
//   reset     asynchronous active-low reset
//   restart_i reload the counter to 0
//   en_i      count enable
//   tick_o    one-cycle tick every DIV enabled cycles
module uart_baud_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // tick_o depends only on the registered count so the caller may derive
    // restart_i from logic that also consumes the tick.
    assign tick_o = en_i && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_cfg.sv
// Parametrised full-duplex UART (start, DATA_BITS LSB first, optional
// parity, STOP_BITS stops). Oversampling receiver with 2-flop synchroniser
// and false-start rejection; framing and parity errors reported separately.
//   clk, reset                      system clock, async active-low reset
//   rxEn, rxIn                      receiver enable, serial input
//   rxBusy, rxDone, rxErr,
//   rxParityErr, rxOut              receiver status pulses and last good payload
//   txEn, txStart, txIn             transmitter enable, send request, payload
//   txBusy, txDone, txOut           transmitter status and serial output
//
// state     | meaning
// ST_IDLE   | line idle, waiting for request / falling edge
// ST_START  | start bit (RX: waiting for mid-bit resample)
// ST_DATA   | payload bits, LSB first
// ST_PARITY | parity bit (skipped when PARITY = 0)
// ST_STOP   | stop bit(s); RX checks only the first
module uart_cfg
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE         = 12000000,
    parameter int BAUD_RATE          = 9600,
    parameter int RX_OVERSAMPLE_RATE = 16,
    parameter int DATA_BITS          = 8,
    parameter int PARITY             = 0,
    parameter int STOP_BITS          = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxEn,
    input  logic                 rxIn,
    output logic                 rxBusy,
    output logic                 rxDone,
    output logic                 rxErr,
    output logic                 rxParityErr,
    output logic [DATA_BITS-1:0] rxOut,
    input  logic                 txEn,
    input  logic                 txStart,
    input  logic [DATA_BITS-1:0] txIn,
    output logic                 txBusy,
    output logic                 txDone,
    output logic                 txOut
);

    localparam int TX_DIV = tx_div(CLOCK_RATE, BAUD_RATE);
    localparam int RX_DIV = rx_div(CLOCK_RATE, BAUD_RATE, RX_OVERSAMPLE_RATE);
    localparam int TCW    = $clog2(RX_OVERSAMPLE_RATE);
    localparam logic [3:0]     DB_LAST   = 4'(DATA_BITS - 1);
    localparam logic [3:0]     SB_LAST   = 4'(STOP_BITS - 1);
    localparam logic [TCW-1:0] HALF_LAST = TCW'(RX_OVERSAMPLE_RATE / 2 - 1);
    localparam logic [TCW-1:0] FULL_LAST = TCW'(RX_OVERSAMPLE_RATE - 1);

    if (RX_DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 || RX_OVERSAMPLE_RATE < 4 ||
        (RX_OVERSAMPLE_RATE % 2) != 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_cfg_err
        $error("uart_cfg: unsupported parameter set");
    end

    // ---------------- transmitter ----------------
    uart_state_e          tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic                 tx_par_q, tx_par_d, tx_done_q, tx_done_d, tx_out_q, tx_out_d;
    logic                 tx_tick, tx_restart;

    assign tx_restart = (tx_state_q == ST_IDLE) && txEn && txStart;

    uart_baud_gen #(.DIV(TX_DIV)) u_tx_baud (
        .clk(clk), .reset(reset), .restart_i(tx_restart),
        .en_i(tx_state_q != ST_IDLE), .tick_o(tx_tick)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_par_d   = tx_par_q;
        tx_done_d  = 1'b0;
        if (!txEn) begin
            tx_state_d = ST_IDLE;
        end else begin
            case (tx_state_q)
                ST_IDLE: if (txStart) begin
                    tx_state_d = ST_START;
                    tx_shift_d = txIn;
                    tx_par_d   = parity_bit(9'(txIn), PARITY);
                end
                ST_START: if (tx_tick) begin
                    tx_state_d = ST_DATA;
                    tx_bit_d   = '0;
                end
                ST_DATA: if (tx_tick) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 4'd1;
                    if (tx_bit_q == DB_LAST) begin
                        tx_bit_d = '0;
                        if (PARITY != PARITY_NONE) tx_state_d = ST_PARITY;
                        else                       tx_state_d = ST_STOP;
                    end
                end
                ST_PARITY: if (tx_tick) tx_state_d = ST_STOP;
                ST_STOP: if (tx_tick) begin
                    tx_bit_d = tx_bit_q + 4'd1;
                    if (tx_bit_q == SB_LAST) begin
                        tx_state_d = ST_IDLE;
                        tx_done_d  = 1'b1;
                    end
                end
                default: tx_state_d = ST_IDLE;
            endcase
        end
        // Output bit registered from the next state so txOut changes with the state.
        case (tx_state_d)
            ST_START:  tx_out_d = 1'b0;
            ST_DATA:   tx_out_d = tx_shift_d[0];
            ST_PARITY: tx_out_d = tx_par_d;
            default:   tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= ST_IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_par_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_out_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_par_q   <= tx_par_d;
            tx_done_q  <= tx_done_d;
            tx_out_q   <= tx_out_d;
        end
    end

    assign txBusy = (tx_state_q != ST_IDLE);
    assign txDone = tx_done_q;
    assign txOut  = tx_out_q;

    // ---------------- receiver ----------------
    logic                 rx_sync1_q, rx_sync2_q, rx_prev_q;
    uart_state_e          rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_out_q, rx_out_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [TCW-1:0]       rx_tcnt_q, rx_tcnt_d;
    logic                 rx_pflag_q, rx_pflag_d;
    logic                 rx_done_q, rx_done_d, rx_err_q, rx_err_d, rx_perr_q, rx_perr_d;
    logic                 rx_tick, rx_fall, rx_restart;

    assign rx_fall    = rx_prev_q && !rx_sync2_q;
    assign rx_restart = (rx_state_q == ST_IDLE) && rxEn && rx_fall;

    uart_baud_gen #(.DIV(RX_DIV)) u_rx_baud (
        .clk(clk), .reset(reset), .restart_i(rx_restart),
        .en_i(rx_state_q != ST_IDLE), .tick_o(rx_tick)
    );

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_out_d   = rx_out_q;
        rx_bit_d   = rx_bit_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_pflag_d = rx_pflag_q;
        rx_done_d  = 1'b0;
        rx_err_d   = 1'b0;
        rx_perr_d  = 1'b0;
        if (!rxEn) begin
            rx_state_d = ST_IDLE;
        end else if (rx_state_q == ST_IDLE) begin
            if (rx_fall) begin
                rx_state_d = ST_START;
                rx_tcnt_d  = '0;
                rx_pflag_d = 1'b0;
            end
        end else if (rx_tick) begin
            rx_tcnt_d = rx_tcnt_q + 1'b1;
            case (rx_state_q)
                ST_START: if (rx_tcnt_q == HALF_LAST) begin
                    rx_tcnt_d = '0;
                    rx_bit_d  = '0;
                    // Line back high at mid start bit: glitch, not a frame.
                    if (rx_sync2_q) rx_state_d = ST_IDLE;
                    else            rx_state_d = ST_DATA;
                end
                ST_DATA: if (rx_tcnt_q == FULL_LAST) begin
                    rx_tcnt_d  = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + 4'd1;
                    if (rx_bit_q == DB_LAST) begin
                        if (PARITY != PARITY_NONE) rx_state_d = ST_PARITY;
                        else                       rx_state_d = ST_STOP;
                    end
                end
                ST_PARITY: if (rx_tcnt_q == FULL_LAST) begin
                    rx_tcnt_d  = '0;
                    rx_pflag_d = (rx_sync2_q != parity_bit(9'(rx_shift_q), PARITY));
                    rx_state_d = ST_STOP;
                end
                ST_STOP: if (rx_tcnt_q == FULL_LAST) begin
                    // Re-arm after the first stop bit; further stop bits are not checked.
                    rx_tcnt_d  = '0;
                    rx_state_d = ST_IDLE;
                    if (!rx_sync2_q || rx_pflag_q) begin
                        rx_err_d  = 1'b1;
                        rx_perr_d = rx_pflag_q;
                    end else begin
                        rx_done_d = 1'b1;
                        rx_out_d  = rx_shift_q;
                    end
                end
                default: rx_state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_shift_q <= '0;
            rx_out_q   <= '0;
            rx_bit_q   <= '0;
            rx_tcnt_q  <= '0;
            rx_pflag_q <= 1'b0;
            rx_done_q  <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_sync1_q <= rxIn;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_out_q   <= rx_out_d;
            rx_bit_q   <= rx_bit_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_pflag_q <= rx_pflag_d;
            rx_done_q  <= rx_done_d;
            rx_err_q   <= rx_err_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    assign rxBusy      = (rx_state_q != ST_IDLE);
    assign rxDone      = rx_done_q;
    assign rxErr       = rx_err_q;
    assign rxParityErr = rx_perr_q;
    assign rxOut       = rx_out_q;

endmodule

// File: tb/tb_uart_cfg.sv
module tb_uart_cfg;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [4:0] tx_en, tx_start, rx_en, tx_busy, tx_done, tx_out;
    logic [4:0] rx_busy, rx_done, rx_err, rx_perr;
    logic [8:0] tx_in [5];
    logic       rx_drv;
    logic [7:0] rxo0, rxo1, rxo2;
    logic [4:0] rxo3;
    logic [8:0] rxo4;

    int n_checks = 0;
    int n_pass   = 0;
    int txd_cnt [5];
    int rxd_cnt [5];
    int rxe_cnt [5];
    int rxpe_cnt[5];
    int both_cnt[5];
    logic [8:0] last_rx[5];

    // u0: 8N1 12 MHz / 9600 loopback
    uart_cfg u_dut0 (
        .clk(clk), .reset(reset), .rxEn(rx_en[0]), .rxIn(tx_out[0]), .rxBusy(rx_busy[0]),
        .rxDone(rx_done[0]), .rxErr(rx_err[0]), .rxParityErr(rx_perr[0]), .rxOut(rxo0),
        .txEn(tx_en[0]), .txStart(tx_start[0]), .txIn(tx_in[0][7:0]), .txBusy(tx_busy[0]),
        .txDone(tx_done[0]), .txOut(tx_out[0]));

    // u1: 8E2 12 MHz / 9600 loopback
    uart_cfg #(.PARITY(2), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .reset(reset), .rxEn(rx_en[1]), .rxIn(tx_out[1]), .rxBusy(rx_busy[1]),
        .rxDone(rx_done[1]), .rxErr(rx_err[1]), .rxParityErr(rx_perr[1]), .rxOut(rxo1),
        .txEn(tx_en[1]), .txStart(tx_start[1]), .txIn(tx_in[1][7:0]), .txBusy(tx_busy[1]),
        .txDone(tx_done[1]), .txOut(tx_out[1]));

    // u2: 8O1 receiver driven by the bench; TX_DIV=64, RX_DIV=4, oversample 16
    uart_cfg #(.CLOCK_RATE(1000000), .BAUD_RATE(15625), .PARITY(1)) u_dut2 (
        .clk(clk), .reset(reset), .rxEn(rx_en[2]), .rxIn(rx_drv), .rxBusy(rx_busy[2]),
        .rxDone(rx_done[2]), .rxErr(rx_err[2]), .rxParityErr(rx_perr[2]), .rxOut(rxo2),
        .txEn(tx_en[2]), .txStart(tx_start[2]), .txIn(tx_in[2][7:0]), .txBusy(tx_busy[2]),
        .txDone(tx_done[2]), .txOut(tx_out[2]));

    // u3: 5N1 loopback, TX_DIV=16, RX_DIV=2, oversample 8
    uart_cfg #(.CLOCK_RATE(1000000), .BAUD_RATE(62500), .RX_OVERSAMPLE_RATE(8), .DATA_BITS(5)) u_dut3 (
        .clk(clk), .reset(reset), .rxEn(rx_en[3]), .rxIn(tx_out[3]), .rxBusy(rx_busy[3]),
        .rxDone(rx_done[3]), .rxErr(rx_err[3]), .rxParityErr(rx_perr[3]), .rxOut(rxo3),
        .txEn(tx_en[3]), .txStart(tx_start[3]), .txIn(tx_in[3][4:0]), .txBusy(tx_busy[3]),
        .txDone(tx_done[3]), .txOut(tx_out[3]));

    // u4: 9O2 loopback, TX_DIV=16, RX_DIV=2, oversample 8
    uart_cfg #(.CLOCK_RATE(1000000), .BAUD_RATE(62500), .RX_OVERSAMPLE_RATE(8), .DATA_BITS(9),
               .PARITY(1), .STOP_BITS(2)) u_dut4 (
        .clk(clk), .reset(reset), .rxEn(rx_en[4]), .rxIn(tx_out[4]), .rxBusy(rx_busy[4]),
        .rxDone(rx_done[4]), .rxErr(rx_err[4]), .rxParityErr(rx_perr[4]), .rxOut(rxo4),
        .txEn(tx_en[4]), .txStart(tx_start[4]), .txIn(tx_in[4]), .txBusy(tx_busy[4]),
        .txDone(tx_done[4]), .txOut(tx_out[4]));

    function automatic logic [8:0] rx_out_of(input int i);
        case (i)
            0:       return 9'(rxo0);
            1:       return 9'(rxo1);
            2:       return 9'(rxo2);
            3:       return 9'(rxo3);
            default: return rxo4;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (tx_done[i]) txd_cnt[i]++;
            if (rx_done[i]) begin
                rxd_cnt[i]++;
                last_rx[i] = rx_out_of(i);
            end
            if (rx_err[i])  rxe_cnt[i]++;
            if (rx_perr[i]) rxpe_cnt[i]++;
            if (rx_err[i] && rx_perr[i]) both_cnt[i]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference frame: line levels bit by bit, parity from a count of ones.
    function automatic void build_frame(input logic [8:0] d, input int db, input int par, input int sb,
                                        output logic [15:0] fr, output int n);
        int ones;
        ones = 0;
        fr   = '1;
        n    = 0;
        fr[n] = 1'b0; n++;
        for (int i = 0; i < db; i++) begin
            fr[n] = d[i];
            if (d[i]) ones++;
            n++;
        end
        if (par == 1) begin fr[n] = ((ones % 2) == 0); n++; end
        if (par == 2) begin fr[n] = ((ones % 2) == 1); n++; end
        n += sb;
    endfunction

    task automatic tx_frame(input int u, input logic [8:0] d, input int db, input int par,
                            input int sb, input int div);
        logic [15:0] fr;
        int n, k, td0, rd0, re0;
        build_frame(d, db, par, sb, fr, n);
        td0 = txd_cnt[u]; rd0 = rxd_cnt[u]; re0 = rxe_cnt[u];
        tx_in[u] = d;
        tx_start[u] = 1'b1;
        @(negedge clk);
        tx_start[u] = 1'b0;
        check($sformatf("u%0d_start_latency", u), {tx_busy[u], tx_out[u]}, 2'b10);
        k = 0;
        while (tx_busy[u] && k < n * div + 10) begin
            if ((k % div) == div / 2)
                check($sformatf("u%0d_txbit%0d", u, k / div), tx_out[u], fr[k / div]);
            k++;
            @(negedge clk);
        end
        check($sformatf("u%0d_frame_len", u), k, n * div);
        check($sformatf("u%0d_txdone_at_end", u), tx_done[u], 1'b1);
        repeat (div) @(negedge clk);
        check($sformatf("u%0d_txdone_count", u), txd_cnt[u] - td0, 1);
        check($sformatf("u%0d_rxdone_count", u), rxd_cnt[u] - rd0, 1);
        check($sformatf("u%0d_rx_data", u), last_rx[u], d);
        check($sformatf("u%0d_rxerr_count", u), rxe_cnt[u] - re0, 0);
    endtask

    // Drive one 8O1 frame into u2 (64 cycles per bit) then one idle bit.
    task automatic rx_send(input logic [8:0] d, input logic flip_par, input logic stop_val);
        logic [15:0] fr;
        int n;
        build_frame(d, 8, 1, 1, fr, n);
        if (flip_par) fr[9] = ~fr[9];
        fr[10] = stop_val;
        for (int b = 0; b < n; b++) begin
            rx_drv = fr[b];
            repeat (64) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (64) @(negedge clk);
    endtask

    initial begin : main
        logic [8:0] d, prev;
        int d0, e0, p0, b0, first, blen, t0;
        reset = 1'b0;
        tx_en = '0; tx_start = '0; rx_en = '0; rx_drv = 1'b1;
        for (int i = 0; i < 5; i++) tx_in[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_out", tx_out, 5'h1f);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_rx_busy", rx_busy, 0);
        check("rst_pulses", {tx_done, rx_done, rx_err, rx_perr}, 0);
        check("rst_rx_out0", rxo0, 0);
        check("rst_rx_out4", rxo4, 0);
        reset = 1'b1;
        tx_en = 5'b11011; rx_en = '1;
        repeat (3) @(negedge clk);

        tx_frame(0, 9'h08A, 8, 0, 1, 1250);
        tx_frame(1, 9'h08A, 8, 2, 2, 1250);

        tx_frame(3, 9'h01F, 5, 0, 1, 16);
        tx_frame(3, 9'h015, 5, 0, 1, 16);
        tx_frame(3, 9'h00A, 5, 0, 1, 16);
        tx_frame(4, 9'h1FF, 9, 1, 2, 16);
        tx_frame(4, 9'h155, 9, 1, 2, 16);
        tx_frame(4, 9'h0AA, 9, 1, 2, 16);
        for (int r = 0; r < 3; r++) begin
            tx_frame(3, 9'($urandom_range(0, 31)), 5, 0, 1, 16);
            tx_frame(4, 9'($urandom_range(0, 511)), 9, 1, 2, 16);
        end

        // u2: random good frames
        prev = '0;
        for (int r = 0; r < 3; r++) begin
            d = 9'($urandom_range(0, 255));
            d0 = rxd_cnt[2]; e0 = rxe_cnt[2];
            rx_send(d, 1'b0, 1'b1);
            check("u2_good_done", rxd_cnt[2] - d0, 1);
            check("u2_good_data", last_rx[2], d);
            check("u2_good_noerr", rxe_cnt[2] - e0, 0);
            prev = d;
        end

        // parity bit inverted on 0x55
        d0 = rxd_cnt[2]; e0 = rxe_cnt[2]; p0 = rxpe_cnt[2]; b0 = both_cnt[2];
        rx_send(9'h055, 1'b1, 1'b1);
        check("par_err_count", rxe_cnt[2] - e0, 1);
        check("par_perr_count", rxpe_cnt[2] - p0, 1);
        check("par_coincident", both_cnt[2] - b0, 1);
        check("par_no_done", rxd_cnt[2] - d0, 0);
        check("par_rxout_kept", rxo2, prev[7:0]);

        // stop bit 0 after 0xF0
        d0 = rxd_cnt[2]; e0 = rxe_cnt[2]; p0 = rxpe_cnt[2];
        rx_send(9'h0F0, 1'b0, 1'b0);
        check("frm_err_count", rxe_cnt[2] - e0, 1);
        check("frm_perr_count", rxpe_cnt[2] - p0, 0);
        check("frm_no_done", rxd_cnt[2] - d0, 0);
        check("frm_rxout_kept", rxo2, prev[7:0]);

        // 20-cycle low glitch: busy 3 cycles later, drops at the resample (8 ticks x 4)
        d0 = rxd_cnt[2]; e0 = rxe_cnt[2];
        first = -1; blen = 0;
        rx_drv = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 20) rx_drv = 1'b1;
            if (rx_busy[2]) begin
                blen++;
                if (first < 0) first = c;
            end
        end
        check("false_start_rise", first, 3);
        check("false_start_busy_len", blen, 32);
        check("false_start_no_done", rxd_cnt[2] - d0, 0);
        check("false_start_no_err", rxe_cnt[2] - e0, 0);

        // txEn dropped mid-frame on u0
        rx_en[0] = 1'b0;
        t0 = txd_cnt[0];
        tx_in[0] = 9'h0C3; tx_start[0] = 1'b1;
        @(negedge clk);
        tx_start[0] = 1'b0;
        repeat (4999) @(negedge clk);
        check("abort_pre_busy", tx_busy[0], 1'b1);
        tx_en[0] = 1'b0;
        @(negedge clk);
        check("abort_tx_out", tx_out[0], 1'b1);
        check("abort_tx_busy", tx_busy[0], 1'b0);
        repeat (20) @(negedge clk);
        check("abort_no_done", txd_cnt[0] - t0, 0);
        tx_en[0] = 1'b1; rx_en[0] = 1'b1;
        repeat (10) @(negedge clk);

        // reset asserted mid-frame on u0
        t0 = txd_cnt[0]; d0 = rxd_cnt[0]; e0 = rxe_cnt[0];
        tx_in[0] = 9'h03C; tx_start[0] = 1'b1;
        @(negedge clk);
        tx_start[0] = 1'b0;
        repeat (4999) @(negedge clk);
        check("rstmid_pre_busy", {tx_busy[0], rx_busy[0]}, 2'b11);
        reset = 1'b0;
        #1;
        check("rstmid_tx_out", tx_out[0], 1'b1);
        check("rstmid_tx_busy", tx_busy[0], 1'b0);
        check("rstmid_rx_busy", rx_busy[0], 1'b0);
        repeat (3) @(negedge clk);
        check("rstmid_no_pulses", (txd_cnt[0] - t0) + (rxd_cnt[0] - d0) + (rxe_cnt[0] - e0), 0);
        check("rstmid_rx_out", rxo0, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_cfg.md
# uart_cfg

Parametrised full-duplex UART: the next generation of `Uart8`, with configurable data width, parity mode, stop-bit count and baud rate. The transmitter and receiver run from one system clock. The receiver oversamples, synchronises its input and rejects false start bits. It also reports framing and parity errors separately. It sits between the board pins and the byte-level protocol logic, and its port set stays close to `Uart8` so existing benches port over directly.

## Interface
- `CLOCK_RATE`, 12000000: system clock in Hz.
- `BAUD_RATE`, 9600: line rate in baud.
- `RX_OVERSAMPLE_RATE`, 16: receiver ticks per bit; even, ≥ 4.
- `DATA_BITS`, 8: payload width, 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rxEn` in 1: receiver enable.
- `rxIn` in 1: serial input; asynchronous to `clk`.
- `rxBusy` out 1: a frame is in progress.
- `rxDone` out 1: one-cycle pulse; a good frame was received.
- `rxErr` out 1: one-cycle pulse; a framing or parity error occurred.
- `rxParityErr` out 1: one-cycle pulse, coincident with `rxErr` when the parity check failed.
- `rxOut` out DATA_BITS: the last good payload.
- `txEn` in 1: transmitter enable.
- `txStart` in 1: level request to send `txIn`.
- `txIn` in DATA_BITS: payload to send.
- `txBusy` out 1: a frame is being shifted out.
- `txDone` out 1: one-cycle pulse at the end of a frame.
- `txOut` out 1: serial output; idles high.

## Operation
- Divisors are computed at elaboration with integer truncation.
  - `TX_DIV = CLOCK_RATE/BAUD_RATE`.
  - `RX_DIV = CLOCK_RATE/(BAUD_RATE*RX_OVERSAMPLE_RATE)`.
  - `RX_DIV` must be ≥ 1; elaboration fails otherwise.
- Frame format: start bit (0), `DATA_BITS` bits LSB first, optional parity bit, `STOP_BITS` stop bits (1).
- Parity bit value:
  - odd: XOR of the data bits, inverted.
  - even: XOR of the data bits.
- TX state machine: IDLE → START → DATA → PARITY (skipped when `PARITY`=0) → STOP → IDLE.
  - In IDLE with `txEn`=1 and `txStart`=1, latch `txIn` and enter START.
  - `txStart` is ignored while busy.
  - If `txStart` is held high, frames are sent back-to-back.
  - If `txEn` drops mid-frame, the frame aborts: `txOut`=1, IDLE, no `txDone`.
- RX input path: `rxIn` passes through a 2-flop synchroniser whose flops reset to 1. The state machine sees only the synchronised value.
- RX state machine: IDLE → START → DATA → PARITY (skipped when `PARITY`=0) → STOP → IDLE.
  - IDLE→START on a synchronised falling edge while `rxEn`=1.
  - The start bit is resampled at tick `RX_OVERSAMPLE_RATE/2`. If it reads 1, it is a false start: return to IDLE with no flags.
  - Each later bit is sampled every `RX_OVERSAMPLE_RATE` ticks, i.e. at mid-bit.
  - Only the first stop bit is checked. A 0 there is a framing error.
  - On a good frame: load `rxOut` and pulse `rxDone`.
  - On an error: pulse `rxErr` (plus `rxParityErr` when the parity check failed). `rxOut` is unchanged.
  - If `rxEn` drops mid-frame, the frame aborts: IDLE, no flags.
- Reset values:
  - `txOut`=1.
  - `txBusy`, `txDone`, `rxBusy`, `rxDone`, `rxErr`, `rxParityErr` = 0.
  - `rxOut`=0.
  - Both state machines in IDLE.
  - Divider counters at 0.
- Reset asserted mid-frame clears everything immediately, with no pulses.

## Timing
- TX:
  - `txBusy` rises, and `txOut` falls, in the cycle after `txStart` is accepted.
  - Each bit lasts exactly `TX_DIV` cycles.
  - Frame length is `(1+DATA_BITS+(PARITY!=0)+STOP_BITS)*TX_DIV` cycles.
  - After the last stop bit, `txDone` pulses for one cycle and `txBusy` falls in that same cycle.
  - A new `txStart` is accepted in that same cycle.
- RX:
  - `rxBusy` rises 3 cycles after the falling edge on `rxIn`.
  - `rxDone`/`rxErr` pulse 1 cycle after the first stop bit is sampled; `rxBusy` falls in that same cycle.
  - The receiver re-arms immediately, which tolerates a sender running up to half a bit fast.

## Structure
- `uart_pkg` holds:
  - parity constants `PARITY_NONE`/`PARITY_ODD`/`PARITY_EVEN`;
  - the shared state encoding `ST_IDLE`/`ST_START`/`ST_DATA`/`ST_PARITY`/`ST_STOP`;
  - the divisor functions.
- Sub-module `uart_baud_gen` is a loadable divider with a tick output, instantiated once each for TX and RX. It restarts at 0 on every frame start.

## Test plan
All scenarios use 12 MHz, 9600 baud, oversample 16 (`TX_DIV`=1250, `RX_DIV`=78) unless stated.
- Loopback, 8N1, `txIn`=0x8A → `txBusy` for 12500 cycles, one `txDone`; `rxDone` with `rxOut`=0x8A; `rxErr` never asserted.
- 8E2, `txIn`=0x8A → the parity bit on `txOut` is 1 and the frame is 15000 cycles; the receiver gets 0x8A.
- 8O1 receiver, frame 0x55 driven with its parity bit inverted → `rxErr` and `rxParityErr` pulse together, no `rxDone`, `rxOut` keeps its previous value.
- `rxIn` held low for 20 cycles, then high → no `rxDone` or `rxErr`; `rxBusy` falls at the start-bit resample.
- Stop bit driven 0 after 0xF0 → `rxErr`=1 and `rxParityErr`=0.
- `txEn` dropped, and separately `reset`=0 asserted, at cycle 5000 of a frame → `txOut`=1 and `txBusy`=0 within one cycle, with no `txDone`; for `reset`, also `rxBusy`=0 within one cycle.
- `DATA_BITS`=5 and `DATA_BITS`=9 loopbacks of all-ones and alternating patterns are received exactly.
